// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation, one-outstanding memory
// handshake, and a small PC-tagged instruction FIFO with redirect/flush support.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int IW    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect,
  input  logic [AW-1:0]                redirect_pc,
  output logic                         mem_req,
  output logic [AW-1:0]                mem_addr,
  input  logic                         mem_ack,
  input  logic [IW-1:0]                mem_rdata,
  output logic                         out_valid,
  output logic [IW-1:0]                out_instr,
  output logic [AW-1:0]                out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {Req, Squash} fetchState;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } qEntry;

  fetchState     state, stateNext;
  logic [AW-1:0] fetchPc, fetchPcNext;
  logic [AW-1:0] pendPc, pendPcNext;
  logic [PW-1:0] rdPtr, rdPtrNext, wrPtr, wrPtrNext;
  logic [CW-1:0] count, countNext;
  logic [AW-1:0] target;
  logic          push, pop, staleAck;
  logic          unusedLowBits;
  qEntry         queue [DEPTH];

  assign target        = {redirect_pc[AW-1:2], 2'b00};
  assign unusedLowBits = ^redirect_pc[1:0];

  // Request depends only on registered state and count, gated off while reset is held.
  assign mem_req   = reset && ((state == Squash) || (count < CW'(DEPTH)));
  assign mem_addr  = fetchPc;
  assign out_valid = reset && (count != '0);
  assign out_pc    = queue[rdPtr].pc;
  assign out_instr = queue[rdPtr].instr;
  assign occupancy = count;

  assign push     = mem_req && mem_ack && (state == Req) && !redirect;
  assign staleAck = mem_req && mem_ack && (state == Squash);
  assign pop      = out_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stateNext   = state;
    fetchPcNext = fetchPc;
    pendPcNext  = pendPc;
    rdPtrNext   = rdPtr;
    wrPtrNext   = wrPtr;
    countNext   = count;

    if (redirect) begin
      rdPtrNext = '0;
      wrPtrNext = '0;
      countNext = '0;
      if (!mem_req || mem_ack) begin
        stateNext   = Req;
        fetchPcNext = target;
      end else begin
        // A request is still in flight; let it finish and drop its data.
        stateNext  = Squash;
        pendPcNext = target;
      end
    end else begin
      if (push) begin
        wrPtrNext   = wrPtr + PW'(1);
        fetchPcNext = fetchPc + AW'(4);
      end
      if (pop) rdPtrNext = rdPtr + PW'(1);
      if (push && !pop)      countNext = count + CW'(1);
      else if (!push && pop) countNext = count - CW'(1);
      if (staleAck) begin
        stateNext   = Req;
        fetchPcNext = pendPc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= Req;
      fetchPc <= '0;
      pendPc  <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      pendPc  <= pendPcNext;
      rdPtr   <= rdPtrNext;
      wrPtr   <= wrPtrNext;
      count   <= countNext;
    end
  end

  // NOTE: FIFO storage is not reset; count gates out_valid so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) queue[wrPtr] <= '{pc: fetchPc, instr: mem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a behavioural instruction memory whose
// wait-state count is programmable; rdata is always addr>>2.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, redirect, mem_req, mem_ack, out_valid, out_ready;
  logic [15:0] redirect_pc, mem_addr, mem_rdata, out_instr, out_pc;
  logic [2:0]  occupancy;

  int vectors     = 0;
  int miscompares = 0;
  int waitCycles  = 0;
  int waitCnt     = 0;
  logic reqNow, ackNow;

  fetch_queue #(.DEPTH(4), .AW(16), .IW(16)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive this cycle's inputs, then let the memory model answer the request.
  task automatic apply(input logic rst, input logic rdr, input logic [15:0] rpc, input logic rdy);
    reset       = rst;
    redirect    = rdr;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    reqNow    = mem_req;
    mem_ack   = mem_req && (waitCnt == waitCycles);
    mem_rdata = mem_addr >> 2;
    ackNow    = mem_ack;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reqNow && !ackNow) waitCnt++;
    else waitCnt = 0;
    @(negedge clk);
  endtask

  task automatic doReset(input int waits);
    waitCycles = waits;
    apply(1'b0, 1'b0, 16'h0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] heads [5];
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0; reqNow = 1'b0; ackNow = 1'b0;
    @(negedge clk);

    // Reset held two cycles, then a zero-wait stream.
    doReset(0);
    doReset(0);
    check("rst_req", mem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 16'h0000);
    check("first_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      check($sformatf("stream_valid%0d", i), out_valid, 1);
      check($sformatf("stream_pc%0d", i), out_pc, 16'(4 * i));
      check($sformatf("stream_instr%0d", i), out_instr, 16'(i));
      tick();
    end

    // Fill with no consumer, then release one entry.
    doReset(0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check($sformatf("fill_addr%0d", i), mem_addr, 16'(4 * i));
      tick();
    end
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("full_occ", occupancy, 4);
    check("full_req", mem_req, 0);
    check("full_head", out_pc, 16'h0000);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b0);
    check("refill_req", mem_req, 1);
    check("refill_addr", mem_addr, 16'h0010);
    check("refill_occ", occupancy, 3);
    check("refill_head", out_pc, 16'h0004);
    tick();
    heads = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014};
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      check($sformatf("drain_pc%0d", i), out_pc, heads[i]);
      check($sformatf("drain_instr%0d", i), out_instr, heads[i] >> 2);
      tick();
    end

    // Redirect in the same cycle as the ack of 0x8.
    doReset(0);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      tick();
    end
    apply(1'b1, 1'b1, 16'h0043, 1'b1);
    check("rdack_addr", mem_addr, 16'h0008);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("rdack_valid", out_valid, 0);
    check("rdack_occ", occupancy, 0);
    check("rdack_addr2", mem_addr, 16'h0040);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("rdack_head", out_pc, 16'h0040);
    check("rdack_instr", out_instr, 16'h0010);
    tick();

    // Squash: 3 wait states, redirect to 0x80 then 0xC0 while 0x8 waits.
    doReset(3);
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      tick();
    end
    apply(1'b1, 1'b1, 16'h0080, 1'b1);
    check("sq_addr0", mem_addr, 16'h0008);
    tick();
    apply(1'b1, 1'b1, 16'h00C0, 1'b1);
    check("sq_req1", mem_req, 1);
    check("sq_addr1", mem_addr, 16'h0008);
    check("sq_valid1", out_valid, 0);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("sq_addr2", mem_addr, 16'h0008);
    check("sq_ack", mem_ack, 1);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("sq_target", mem_addr, 16'h00C0);
    check("sq_valid3", out_valid, 0);
    check("sq_occ3", occupancy, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      tick();
    end
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("sq_head_valid", out_valid, 1);
    check("sq_head_pc", out_pc, 16'h00C0);
    check("sq_head_instr", out_instr, 16'h0030);
    tick();

    // Address wrap past 0xFFFC.
    doReset(0);
    apply(1'b1, 1'b1, 16'hFFF8, 1'b1);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b1);
    check("wrap_addr", mem_addr, 16'hFFF8);
    check("wrap_valid", out_valid, 0);
    tick();
    heads[0] = 16'hFFF8; heads[1] = 16'hFFFC; heads[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      check($sformatf("wrap_pc%0d", i), out_pc, heads[i]);
      check($sformatf("wrap_instr%0d", i), out_instr, heads[i] >> 2);
      tick();
    end

    // Reset during a wait with three entries queued.
    doReset(1);
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      tick();
    end
    check("mid_occ_before", occupancy, 3);
    check("mid_addr_before", mem_addr, 16'h000C);
    apply(1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    check("mid_req", mem_req, 0);
    check("mid_valid", out_valid, 0);
    check("mid_occ", occupancy, 0);
    apply(1'b1, 1'b0, 16'h0, 1'b0);
    check("mid_rel_req", mem_req, 1);
    check("mid_rel_addr", mem_addr, 16'h0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle core's decode and register-fetch stage. It generates sequential byte-addressed fetch PCs in steps of 4, which is the core's instruction stride. It drives a request/acknowledge handshake to instruction memory and buffers returned instructions, each tagged with its PC, in a small FIFO. The core consumes entries through a valid/ready interface, and a taken branch or branch-exchange redirect flushes the queue and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- AW, 16: address and PC width.
- IW, 16: instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  AW  redirect target; bits [1:0] are ignored and forced to 00.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  AW  fetch byte address.
- mem_ack  in  1  memory response; mem_rdata is valid in the same cycle.
- mem_rdata  in  IW  fetched instruction.
- out_valid  out  1  queue head is valid.
- out_instr  out  IW  head instruction.
- out_pc  out  AW  head PC.
- out_ready  in  1  consumer accepts the head this cycle.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

## Operation
- Storage: circular buffer of {pc, instr} with registered read pointer, write pointer and count.
  - out_valid = (count != 0).
  - out_instr and out_pc come from the head entry.
- State machine, one outstanding request at most:
  - REQ: mem_req = (count < DEPTH); mem_addr = fetch_pc.
    - On mem_ack: push {fetch_pc, mem_rdata} and set fetch_pc += 4 (mod 2^AW; 0xFFFC wraps to 0x0000).
  - SQUASH: mem_req = 1; mem_addr = the stale address.
    - On mem_ack: discard the data, set fetch_pc = pending target, go to REQ.
- Request rule: once mem_req is asserted, mem_req and mem_addr stay stable until mem_ack. Count cannot rise while a request waits, so this holds.
- mem_ack is ignored while mem_req = 0.
- Pop: out_valid & out_ready advances the head.
  - Push and pop in the same cycle leave count unchanged.
  - A push never happens when count = DEPTH, because mem_req is low.
- Redirect (takes priority over everything except reset):
  - Next cycle: count = 0, pointers = 0, out_valid = 0.
  - Any pop in the redirect cycle still counts as consumed.
  - If mem_ack occurs in the redirect cycle, or no request is waiting: the data is discarded, fetch_pc = redirect_pc & ~3, state = REQ.
  - If a request is waiting and not acked: state = SQUASH, and the target is latched.
  - A redirect while in SQUASH overwrites the latched target and stays in SQUASH.
- Reset (reset = 0 at an edge):
  - state = REQ, fetch_pc = 0x0000, count = 0, pointers = 0.
  - Outputs: mem_req = 0 and out_valid = 0 during reset; occupancy = 0.
  - Reset overrides redirect and mem_ack.
  - Reset asserted mid-wait abandons the request. The instruction memory shares the same reset.

## Timing
- First request: mem_req = 1 with mem_addr = 0x0000 in the first cycle after reset is released.
- Fetch-to-output latency: an entry acked in cycle T appears at the head in cycle T+1 (when the queue was empty).
- Throughput: with zero-wait memory (mem_ack in the same cycle as mem_req), one instruction enters per cycle and one leaves per cycle.
- Full stall: mem_req drops in the cycle count reaches DEPTH. After a pop, mem_req returns in the next cycle.
- Redirect latency: the redirect is seen at edge T. The target request is issued in cycle T+1 (no squash) or in the cycle after the stale ack (squash). The target instruction reaches the head one cycle after its ack.
- No combinational path from out_ready or redirect to mem_req or mem_addr. mem_req depends only on registered state and count.

## Test plan
- Reset/stream: hold reset = 0 for 2 cycles, zero-wait memory returning rdata = addr>>2, out_ready = 1 → out_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles with out_instr = 0, 1, 2, 3; first out_valid one cycle after the first ack.
- Fill/backpressure: out_ready = 0 with zero-wait memory → 4 acks, occupancy = 4, mem_req = 0; one out_ready pulse → head PC 0x0 consumed, mem_req = 1 with mem_addr = 0x10 in the next cycle, order preserved.
- Redirect on ack: redirect = 1 with redirect_pc = 0x0043 in the same cycle as the ack of 0x8 → that data is dropped, out_valid = 0 in the next cycle, next mem_addr = 0x0040, next out_pc = 0x0040.
- Squash: memory with 3 wait cycles; redirect to 0x0080 while 0x8 waits → mem_addr holds 0x8 until its ack, that data is not queued, then mem_addr = 0x0080; a second redirect to 0x00C0 during the wait → fetch resumes at 0x00C0.
- Wrap: redirect to 0xFFF8 → out_pc = 0xFFF8, 0xFFFC, 0x0000.
- Reset mid-operation: reset = 0 during a wait with occupancy = 3 → next cycle mem_req = 0, out_valid = 0, occupancy = 0; after release, mem_addr = 0x0000.
